// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : 128 x 32 word-addressed data memory for the single-cycle MIPS
//            core, with combinational reads, bench preload, access counters
//            and a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              proto_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              proto_err_q, proto_err_d;

    logic w_a_ok;
    logic w_ld_ok;
    logic w_sel;
    logic w_rd_cyc;
    logic w_wr_cyc;
    logic w_bad_cyc;

    // A full-depth array makes every address legal; only reduced builds need a range check.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
            assign w_a_ok  = 1'b1;
            assign w_ld_ok = 1'b1;
        end else begin : g_reduced_depth
            localparam logic [ADDR_W:0] c_DEPTH_LIM = DEPTH[ADDR_W:0];
            assign w_a_ok  = ({1'b0, A}       < c_DEPTH_LIM);
            assign w_ld_ok = ({1'b0, ld_addr} < c_DEPTH_LIM);
        end
    endgenerate

    assign w_sel     = ~CEN;
    assign w_rd_cyc  = w_sel & ~OEN;
    assign w_wr_cyc  = w_sel & ~WEN;
    assign w_bad_cyc = w_sel & ((WEN == OEN) | ~w_a_ok);

    always_comb begin
        ReadDataMem = '0;
        if (w_rd_cyc && w_a_ok) begin
            ReadDataMem = mem_q[A];
        end
    end

    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        proto_err_d = proto_err_q | w_bad_cyc;
        if (w_rd_cyc && (rd_cnt_q != {CNT_W{1'b1}})) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (w_wr_cyc && (wr_cnt_q != {CNT_W{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    // The preload is issued last so it overrides a core write to the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (w_wr_cyc && w_a_ok) begin
                mem_q[A] <= Data2Mem;
            end
            if (ld_en && w_ld_ok) begin
                mem_q[ld_addr] <= ld_data;
            end
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for data_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] Data2Mem;
    logic [31:0] ReadDataMem;
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        proto_err;

    int tests;
    int fails;

    data_mem_responder #(
        .ADDR_W(7),
        .DATA_W(32),
        .DEPTH (128),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CEN        (CEN),
        .WEN        (WEN),
        .OEN        (OEN),
        .A          (A),
        .Data2Mem   (Data2Mem),
        .ReadDataMem(ReadDataMem),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic cen, input logic wen, input logic oen,
                           input logic [6:0] a, input logic [31:0] d);
        CEN      = cen;
        WEN      = wen;
        OEN      = oen;
        A        = a;
        Data2Mem = d;
    endtask

    task automatic do_reset();
        set_bus(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
        ld_en   = 1'b0;
        ld_addr = 7'h00;
        ld_data = 32'h0;
        rst_n   = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;

        // Reset state
        do_reset();
        check("reset_rdata", ReadDataMem, 32'h0);
        check("reset_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        check("reset_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        check("reset_err", {31'h0, proto_err}, 32'h0);

        // 1: read of a cleared word
        set_bus(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
        #2;
        check("t1_rdata", ReadDataMem, 32'h0);
        cyc();
        check("t1_rd_cnt", {16'h0, rd_cnt}, 32'h1);
        check("t1_err", {31'h0, proto_err}, 32'h0);

        // 2: store then load same address
        do_reset();
        set_bus(1'b0, 1'b0, 1'b1, 7'h10, 32'hDEADBEEF);
        #2;
        check("t2_rdata_during_wr", ReadDataMem, 32'h0);
        cyc();
        set_bus(1'b0, 1'b1, 1'b0, 7'h10, 32'h0);
        #2;
        check("t2_rdata", ReadDataMem, 32'hDEADBEEF);
        cyc();
        check("t2_wr_cnt", {16'h0, wr_cnt}, 32'h1);
        check("t2_rd_cnt", {16'h0, rd_cnt}, 32'h1);
        check("t2_err", {31'h0, proto_err}, 32'h0);

        // 3: preload collides with core write, preload wins
        do_reset();
        set_bus(1'b0, 1'b0, 1'b1, 7'h7F, 32'hFFFFFFFF);
        ld_en   = 1'b1;
        ld_addr = 7'h7F;
        ld_data = 32'h12345678;
        cyc();
        check("t3_wr_cnt", {16'h0, wr_cnt}, 32'h1);
        // different addresses: both land
        set_bus(1'b0, 1'b0, 1'b1, 7'h03, 32'h33333333);
        ld_addr = 7'h01;
        ld_data = 32'h11111111;
        cyc();
        ld_en = 1'b0;
        set_bus(1'b0, 1'b1, 1'b0, 7'h7F, 32'h0);
        #2;
        check("t3_collide_rdata", ReadDataMem, 32'h12345678);
        cyc();
        set_bus(1'b0, 1'b1, 1'b0, 7'h01, 32'h0);
        #2;
        check("t3_ld_rdata", ReadDataMem, 32'h11111111);
        cyc();
        set_bus(1'b0, 1'b1, 1'b0, 7'h03, 32'h0);
        #2;
        check("t3_core_rdata", ReadDataMem, 32'h33333333);
        cyc();
        check("t3_wr_cnt_final", {16'h0, wr_cnt}, 32'h2);
        check("t3_err", {31'h0, proto_err}, 32'h0);

        // 4: read/write conflict
        do_reset();
        set_bus(1'b0, 1'b0, 1'b0, 7'h02, 32'hA5A5A5A5);
        #2;
        check("t4_rdata_old", ReadDataMem, 32'h0);
        cyc();
        check("t4_err", {31'h0, proto_err}, 32'h1);
        check("t4_rd_cnt", {16'h0, rd_cnt}, 32'h1);
        check("t4_wr_cnt", {16'h0, wr_cnt}, 32'h1);
        set_bus(1'b0, 1'b1, 1'b0, 7'h02, 32'h0);
        #2;
        check("t4_rdata_new", ReadDataMem, 32'hA5A5A5A5);
        cyc();
        check("t4_err_sticky", {31'h0, proto_err}, 32'h1);
        check("t4_rd_cnt2", {16'h0, rd_cnt}, 32'h2);

        // NOP_SEL sets the flag without counting
        do_reset();
        set_bus(1'b0, 1'b1, 1'b1, 7'h04, 32'h0);
        #2;
        check("nop_rdata", ReadDataMem, 32'h0);
        cyc();
        check("nop_err", {31'h0, proto_err}, 32'h1);
        check("nop_cnts", {rd_cnt, wr_cnt}, 32'h0);

        // 5: double-word store and load
        do_reset();
        set_bus(1'b0, 1'b0, 1'b1, 7'h20, 32'h01020304);
        cyc();
        set_bus(1'b0, 1'b0, 1'b1, 7'h21, 32'h05060708);
        cyc();
        set_bus(1'b0, 1'b1, 1'b0, 7'h20, 32'h0);
        #2;
        check("t5_lo", ReadDataMem, 32'h01020304);
        cyc();
        set_bus(1'b0, 1'b1, 1'b0, 7'h21, 32'h0);
        #2;
        check("t5_hi", ReadDataMem, 32'h05060708);
        cyc();
        check("t5_cnts", {rd_cnt, wr_cnt}, {16'h2, 16'h2});
        set_bus(1'b1, 1'b1, 1'b0, 7'h20, 32'h0);
        #2;
        check("t5_idle_rdata", ReadDataMem, 32'h0);
        cyc();
        check("t5_idle_cnts", {rd_cnt, wr_cnt}, {16'h2, 16'h2});
        check("t5_err", {31'h0, proto_err}, 32'h0);

        // 6: rd_cnt saturation, then asynchronous reset mid-cycle
        do_reset();
        ld_en   = 1'b1;
        ld_addr = 7'h05;
        ld_data = 32'hCAFEF00D;
        cyc();
        ld_en = 1'b0;
        check("t6_ld_no_count", {rd_cnt, wr_cnt}, 32'h0);
        set_bus(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
        repeat (65534) @(posedge clk);
        #1;
        check("t6_rd_fffe", {16'h0, rd_cnt}, 32'h0000FFFE);
        repeat (3) @(posedge clk);
        #1;
        check("t6_rd_sat", {16'h0, rd_cnt}, 32'h0000FFFF);
        check("t6_rdata", ReadDataMem, 32'hCAFEF00D);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdata", ReadDataMem, 32'h0);
        check("t6_rst_cnts", {rd_cnt, wr_cnt}, 32'h0);
        check("t6_rst_err", {31'h0, proto_err}, 32'h0);
        cyc();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
